// File: rtl/aexm_pkg.sv
// Shared definitions for the AEXM front end: fetch sequencer state
// encoding, instruction width and the default reset fetch address.
package aexm_pkg;

  localparam int          INSN_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DSLOT = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef enum logic [1:0] {
    S_INIT  = ST_INIT,
    S_FETCH = ST_FETCH,
    S_DSLOT = ST_DSLOT,
    S_HALT  = ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/aexm_satcnt.sv
// Parameterised up-counter that sticks at all-ones instead of wrapping.
module aexm_satcnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count qualified events, holding at the maximum value once reached.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/aexm_fetch_ctl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the icache
// request/ack handshake, produces decode/stall-tracker enables and applies
// branch redirects including the single delay slot.
module aexm_fetch_ctl
  import aexm_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              gclk,
  input  logic              grst,
  output logic              ic_req,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_ack,
  input  logic              hold,
  input  logic              halt_i,
  input  logic              br_take,
  input  logic              br_dly,
  input  logic [ADDR_W-1:0] br_target,
  output logic              d_en,
  output logic              oena,
  output logic [ADDR_W-1:0] rPC,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_tgt;
  logic [ADDR_W-1:0] r_rpc;
  // Set while a delay-slot redirect is outstanding across a halt.
  logic              r_pend;

  logic              w_active;
  logic              w_kill;
  logic              w_den;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_fpc_inc;
  logic              w_pend_hold;

  assign w_active    = (r_state == S_FETCH) || (r_state == S_DSLOT);
  // Branches are ignored in the delay slot, so only FETCH can kill a word.
  assign w_kill      = br_take && !br_dly && (r_state == S_FETCH);
  assign w_den       = ic_ack && w_active && !hold && !w_kill;
  assign w_br_tgt    = {br_target[ADDR_W-1:2], 2'b00};
  assign w_fpc_inc   = r_fpc + ADDR_W'(4);
  // A delayed branch recorded in the very cycle halt drops must still count.
  assign w_pend_hold = r_pend || (br_take && br_dly);

  // Sequencer state, fetch PC, pending target and last-accepted PC.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_state <= S_INIT;
      r_fpc   <= RESET_PC;
      r_tgt   <= '0;
      r_rpc   <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (br_take && !br_dly) begin
            r_fpc <= w_br_tgt;
            if (halt_i) begin
              r_state <= S_HALT;
              r_pend  <= 1'b0;
            end
          end else if (br_take) begin
            if (w_den) begin
              // Same-cycle word is the delay slot: redirect right after it.
              r_rpc <= r_fpc;
              r_fpc <= w_br_tgt;
            end else begin
              r_tgt <= w_br_tgt;
              if (halt_i) begin
                r_state <= S_HALT;
                r_pend  <= 1'b1;
              end else begin
                r_state <= S_DSLOT;
              end
            end
          end else if (w_den) begin
            r_rpc <= r_fpc;
            r_fpc <= w_fpc_inc;
          end else if (halt_i) begin
            r_state <= S_HALT;
            r_pend  <= 1'b0;
          end
        end
        S_DSLOT: begin
          if (w_den) begin
            r_rpc   <= r_fpc;
            r_fpc   <= r_tgt;
            r_state <= S_FETCH;
          end else if (halt_i) begin
            r_state <= S_HALT;
            r_pend  <= 1'b1;
          end
        end
        S_HALT: begin
          if (br_take) begin
            if (br_dly) begin
              r_tgt  <= w_br_tgt;
              r_pend <= 1'b1;
            end else begin
              r_fpc <= w_br_tgt;
            end
          end
          if (!halt_i) begin
            r_state <= w_pend_hold ? S_DSLOT : S_FETCH;
          end
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  aexm_satcnt #(
    .W(16)
  ) u_stall_cnt (
    .i_clk (gclk),
    .i_rst (grst),
    .i_inc (ic_ack && hold && w_active),
    .o_cnt (stall_cnt)
  );

  assign ic_req  = w_active;
  assign oena    = w_active;
  assign halted  = (r_state == S_HALT);
  assign ic_addr = r_fpc;
  assign rPC     = r_rpc;
  assign d_en    = w_den;

endmodule

// File: tb/tb_aexm_fetch_ctl.sv
// Bench for aexm_fetch_ctl: directed vector table, hand sequences for async
// reset and counter saturation, and randomized traffic against a model.
module tb_aexm_fetch_ctl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        gclk = 1'b0;
  logic        grst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ack;
  logic        hold;
  logic        halt_i;
  logic        br_take;
  logic        br_dly;
  logic [31:0] br_target;
  logic        d_en;
  logic        oena;
  logic [31:0] rPC;
  logic        halted;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  aexm_fetch_ctl #(
    .ADDR_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .gclk      (gclk),
    .grst      (grst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_ack    (ic_ack),
    .hold      (hold),
    .halt_i    (halt_i),
    .br_take   (br_take),
    .br_dly    (br_dly),
    .br_target (br_target),
    .d_en      (d_en),
    .oena      (oena),
    .rPC       (rPC),
    .halted    (halted),
    .stall_cnt (stall_cnt)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    logic        ack, hld, hlt, br, dly;
    logic [31:0] tgt;
    logic        e_den, e_req, e_hlt;
    logic [31:0] e_addr, e_rpc;
    logic [15:0] e_stall;
  } vec_t;

  vec_t tbl[23];

  // Behavioural reference: fetching/halted/slot-pending flags plus PCs.
  bit          m_run, m_halt, m_slot;
  logic [31:0] m_fpc, m_tgt, m_rpc;
  int          m_stall;

  function automatic vec_t mk(input logic a, h, ht, b, d, input logic [31:0] t,
                              input logic ed, er, eh, input logic [31:0] ea, erp,
                              input logic [15:0] es);
    vec_t v;
    v.ack = a; v.hld = h; v.hlt = ht; v.br = b; v.dly = d; v.tgt = t;
    v.e_den = ed; v.e_req = er; v.e_hlt = eh; v.e_addr = ea; v.e_rpc = erp;
    v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic a, h, ht, b, d, input logic [31:0] t);
    ic_ack = a; hold = h; halt_i = ht; br_take = b; br_dly = d; br_target = t;
  endtask

  // Reset held over two edges, released at a falling edge (state INIT).
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 32'h0);
    grst = 1'b1;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    grst = 1'b0;
    m_run = 0; m_halt = 0; m_slot = 0;
    m_fpc = RST_PC; m_tgt = 0; m_rpc = 0; m_stall = 0;
  endtask

  function automatic bit m_fetching();
    return m_run && !m_halt;
  endfunction

  function automatic bit m_den();
    bit kill;
    kill = br_take && !br_dly && m_fetching() && !m_slot;
    return ic_ack && m_fetching() && !hold && !kill;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit          acc;
    logic [31:0] t;
    acc = m_den();
    t   = {br_target[31:2], 2'b00};
    if (m_fetching() && ic_ack && hold && m_stall < 65535) m_stall++;
    if (!m_run) begin
      m_run = 1;
    end else if (m_halt) begin
      if (br_take) begin
        if (br_dly) begin m_tgt = t; m_slot = 1; end
        else m_fpc = t;
      end
      if (!halt_i) m_halt = 0;
    end else if (m_slot) begin
      if (acc) begin m_rpc = m_fpc; m_fpc = m_tgt; m_slot = 0; end
      else if (halt_i) m_halt = 1;
    end else if (br_take && !br_dly) begin
      m_fpc = t;
      if (halt_i) m_halt = 1;
    end else if (br_take) begin
      if (acc) begin m_rpc = m_fpc; m_fpc = t; end
      else begin m_tgt = t; m_slot = 1; if (halt_i) m_halt = 1; end
    end else if (acc) begin
      m_rpc = m_fpc; m_fpc = m_fpc + 32'd4;
    end else if (halt_i) begin
      m_halt = 1;
    end
  endtask

  initial begin
    grst = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0);

    //              ack hld hlt br dly tgt            den req hlt addr          rpc           stall
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h100,  32'h0,    16'd0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h100,  32'h0,    16'd0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h104,  32'h100,  16'd0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h108,  32'h104,  16'd0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h10C,  32'h108,  16'd0);
    tbl[5]  = mk(1, 1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h10C,  32'h108,  16'd0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h10C,  32'h108,  16'd1);
    tbl[7]  = mk(1, 1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h10C,  32'h108,  16'd2);
    tbl[8]  = mk(1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h10C,  32'h108,  16'd3);
    tbl[9]  = mk(1, 0, 0, 1, 0, 32'h3002,     0, 1, 0, 32'h110,  32'h10C,  16'd3);
    tbl[10] = mk(0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h3000, 32'h10C,  16'd3);
    tbl[11] = mk(1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h3000, 32'h10C,  16'd3);
    tbl[12] = mk(0, 0, 0, 1, 1, 32'h803,      0, 1, 0, 32'h3004, 32'h3000, 16'd3);
    tbl[13] = mk(1, 0, 0, 1, 0, 32'h5000,     1, 1, 0, 32'h3004, 32'h3000, 16'd3);
    tbl[14] = mk(1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h800,  32'h3004, 16'd3);
    tbl[15] = mk(1, 0, 0, 1, 1, 32'hC00,      1, 1, 0, 32'h804,  32'h800,  16'd3);
    tbl[16] = mk(1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'hC00,  32'h804,  16'd3);
    tbl[17] = mk(0, 0, 1, 0, 0, 32'h0,        0, 1, 0, 32'hC04,  32'hC00,  16'd3);
    tbl[18] = mk(1, 0, 1, 0, 0, 32'h0,        0, 0, 1, 32'hC04,  32'hC00,  16'd3);
    tbl[19] = mk(0, 0, 1, 1, 0, 32'h900,      0, 0, 1, 32'hC04,  32'hC00,  16'd3);
    tbl[20] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h900,  32'hC00,  16'd3);
    tbl[21] = mk(1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h900,  32'hC00,  16'd3);
    tbl[22] = mk(0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h904,  32'h900,  16'd3);

    // Directed table: reset, streaming, hold, both branch kinds, halt.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].ack, tbl[i].hld, tbl[i].hlt, tbl[i].br, tbl[i].dly, tbl[i].tgt);
      #1;
      $display("vec %0d: ack=%0b hold=%0b halt=%0b br=%0b/%0b d_en=%0b req=%0b addr=%08h rPC=%08h stall=%0d",
               i, ic_ack, hold, halt_i, br_take, br_dly, d_en, ic_req, ic_addr, rPC, stall_cnt);
      chk($sformatf("tbl%0d d_en", i),   d_en,      tbl[i].e_den);
      chk($sformatf("tbl%0d ic_req", i), ic_req,    tbl[i].e_req);
      chk($sformatf("tbl%0d oena", i),   oena,      tbl[i].e_req);
      chk($sformatf("tbl%0d halted", i), halted,    tbl[i].e_hlt);
      chk($sformatf("tbl%0d ic_addr", i), ic_addr,  tbl[i].e_addr);
      chk($sformatf("tbl%0d rPC", i),    rPC,       tbl[i].e_rpc);
      chk($sformatf("tbl%0d stall", i),  stall_cnt, tbl[i].e_stall);
      @(negedge gclk);
    end

    // Hand sequence: enter DSLOT, then assert reset between clock edges.
    drive(0, 0, 0, 1, 1, 32'hA00);
    #1;
    chk("dslot entry d_en", d_en, 1'b0);
    @(negedge gclk);
    drive(1, 1, 0, 0, 0, 32'h0);
    #1;
    chk("dslot ic_req", ic_req, 1'b1);
    chk("dslot ic_addr", ic_addr, 32'h904);
    #2;
    grst = 1'b1;
    ic_ack = 1'b1; hold = 1'b0;
    #1;
    $display("async reset: req=%0b addr=%08h rPC=%08h d_en=%0b oena=%0b halted=%0b stall=%0d",
             ic_req, ic_addr, rPC, d_en, oena, halted, stall_cnt);
    chk("areset ic_req",  ic_req,    1'b0);
    chk("areset ic_addr", ic_addr,   RST_PC);
    chk("areset rPC",     rPC,       32'h0);
    chk("areset d_en",    d_en,      1'b0);
    chk("areset oena",    oena,      1'b0);
    chk("areset halted",  halted,    1'b0);
    chk("areset stall",   stall_cnt, 16'd3 - 16'd3);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic h;
      h = halt_i;
      if ($urandom_range(0, 99) < 4) h = !h;
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20, h,
            $urandom_range(0, 99) < 10, $urandom_range(0, 1) == 1, $urandom);
      #1;
      $display("rnd %0d: ack=%0b hold=%0b halt=%0b br=%0b/%0b tgt=%08h d_en=%0b addr=%08h rPC=%08h",
               i, ic_ack, hold, halt_i, br_take, br_dly, br_target, d_en, ic_addr, rPC);
      chk($sformatf("rnd%0d d_en", i),    d_en,      m_den());
      chk($sformatf("rnd%0d ic_req", i),  ic_req,    m_fetching());
      chk($sformatf("rnd%0d oena", i),    oena,      m_fetching());
      chk($sformatf("rnd%0d halted", i),  halted,    m_halt);
      chk($sformatf("rnd%0d ic_addr", i), ic_addr,   m_fpc);
      chk($sformatf("rnd%0d rPC", i),     rPC,       m_rpc);
      chk($sformatf("rnd%0d stall", i),   stall_cnt, m_stall[15:0]);
      model_step();
      @(negedge gclk);
    end

    // Saturation: continuous held acks for more than 65535 cycles.
    do_reset();
    drive(1, 1, 0, 0, 0, 32'h0);
    @(negedge gclk);
    repeat (1000) @(negedge gclk);
    $display("sat: after 1000 held acks stall=%0d", stall_cnt);
    chk("sat stall 1000", stall_cnt, 16'd1000);
    repeat (64535) @(negedge gclk);
    $display("sat: after 65535 held acks stall=%0d", stall_cnt);
    chk("sat stall max", stall_cnt, 16'hFFFF);
    repeat (5) @(negedge gclk);
    $display("sat: after 65540 held acks stall=%0d addr=%08h", stall_cnt, ic_addr);
    chk("sat stall hold", stall_cnt, 16'hFFFF);
    chk("sat ic_addr",    ic_addr,   RST_PC);
    chk("sat d_en",       d_en,      1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
